// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// The zero-register index discards writes and never forwards.
package wb_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZR   = 5'd31;
  localparam int       NREQ_DEF = 3;
  localparam int       CNT_W    = 16;

  function automatic logic is_zr(input reg_idx_t idx);
    return idx == REG_ZR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scan upward from ptr, first valid wins.
// ptr moves just past the winner and holds when nothing is valid.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[wrap(ptr, k)]) begin
        found              = 1'b1;
        grant[wrap(ptr, k)] = 1'b1;
        ptr_nxt            = wrap(ptr, k + 1);
      end
    end
    // No acceptance may be signalled while held in reset
    if (reset) begin
      grant   = '0;
      ptr_nxt = ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin pick, one staging register,
// zero-register drop counter and forwarding compare.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][4:0]       req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       we3,
  output logic [4:0]                 ra3,
  output logic [WIDTH-1:0]           wd3,
  input  logic [4:0]                 ra1,
  input  logic [4:0]                 ra2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [WIDTH-1:0]           fwd_data,
  output logic [CNT_W-1:0]           drop_cnt
);

  logic [NREQ-1:0]  grant;
  logic             any;
  reg_idx_t         sel_addr;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any       = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3      <= 1'b0;
      ra3      <= '0;
      wd3      <= '0;
      drop_cnt <= '0;
    end else if (any && is_zr(sel_addr)) begin
      // Accepted but discarded; ra3/wd3 keep the last real write
      we3 <= 1'b0;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end else if (any) begin
      we3 <= 1'b1;
      ra3 <= sel_addr;
      wd3 <= sel_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign fwd_hit1 = we3 && (ra3 == ra1) && !is_zr(ra1);
  assign fwd_hit2 = we3 && (ra3 == ra2) && !is_zr(ra2);
  assign fwd_data = wd3;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard:
// stimulus pushes expected writes, a monitor pops on we3.
module tb_wb_arbiter;

  localparam int W = 64;
  localparam int N = 3;

  typedef struct {
    logic [4:0]   a;
    logic [W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0][4:0] req_addr;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]      req_ready;
  logic              we3;
  logic [4:0]        ra3;
  logic [W-1:0]      wd3;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [W-1:0]      fwd_data;
  logic [15:0]       drop_cnt;

  int  tests = 0;
  int  fails = 0;
  int  nwr   = 0;
  wr_t exp_q[$];

  wb_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we3       (we3),
    .ra3       (ra3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the next expected one
  always @(negedge clk) begin
    if (reset === 1'b0 && we3 === 1'b1) begin
      nwr++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got ra3=%0d wd3=%h want none",
                 ra3, wd3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_ra3", W'(ra3), W'(e.a));
        chk("wr_wd3", wd3, e.d);
      end
    end
  end

  // One cycle: drive valids, check ready, record expected writes
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] rdy,
                     input string nm);
    req_valid = v;
    #1;
    chk(nm, W'(req_ready), W'(rdy));
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && req_addr[i] != 5'd31) begin
        exp_q.push_back('{a: req_addr[i], d: req_data[i]});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    ra1       = 5'd0;
    ra2       = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(req_ready), W'(0));
    chk("rst_we3", W'(we3), W'(0));
    chk("rst_ra3", W'(ra3), W'(0));
    chk("rst_wd3", wd3, W'(0));
    chk("rst_drop", W'(drop_cnt), W'(0));
    chk("rst_hits", W'({fwd_hit1, fwd_hit2}), W'(0));

    // Round robin with everyone valid
    req_valid   = '0;
    req_addr[0] = 5'd1; req_data[0] = 64'h1111;
    req_addr[1] = 5'd2; req_data[1] = 64'h2222;
    req_addr[2] = 5'd3; req_data[2] = 64'h3333;
    reset = 1'b0;
    cyc(3'b111, 3'b001, "rr_g0");
    cyc(3'b111, 3'b010, "rr_g1");
    cyc(3'b111, 3'b100, "rr_g2");
    cyc(3'b111, 3'b001, "rr_g0b");
    cyc(3'b111, 3'b010, "rr_g1b");
    cyc(3'b111, 3'b100, "rr_g2b");
    cyc(3'b000, 3'b000, "idle");
    chk("idle_we3", W'(we3), W'(0));
    chk("hold_ra3", W'(ra3), W'(3));
    chk("hold_wd3", wd3, 64'h3333);

    // Single requester 2
    req_addr[2] = 5'd5; req_data[2] = 64'hDEAD_BEEF;
    cyc(3'b100, 3'b100, "r2_ready");
    chk("r2_we3", W'(we3), W'(1));
    chk("r2_ra3", W'(ra3), W'(5));
    chk("r2_wd3", wd3, 64'hDEAD_BEEF);

    // Three drops to the zero register
    req_addr[0] = 5'd31; req_data[0] = 64'hBAD;
    ra1 = 5'd31; ra2 = 5'd31;
    cyc(3'b001, 3'b001, "drop1");
    chk("drop_hits", W'({fwd_hit1, fwd_hit2}), W'(0));
    cyc(3'b001, 3'b001, "drop2");
    cyc(3'b001, 3'b001, "drop3");
    chk("drop_we3", W'(we3), W'(0));
    chk("drop_cnt3", W'(drop_cnt), W'(3));

    // Forwarding from a staged write to reg 7
    req_addr[1] = 5'd7; req_data[1] = 64'h77;
    ra1 = 5'd7; ra2 = 5'd8;
    cyc(3'b010, 3'b010, "fwd_wr");
    chk("fwd_hit1", W'(fwd_hit1), W'(1));
    chk("fwd_hit2", W'(fwd_hit2), W'(0));
    chk("fwd_data", fwd_data, 64'h77);
    cyc(3'b000, 3'b000, "fwd_idle");
    chk("fwd_off", W'(fwd_hit1), W'(0));

    // Same register twice: grant order decides, last wins
    req_addr[0] = 5'd9; req_data[0] = 64'hA;
    req_addr[1] = 5'd9; req_data[1] = 64'hB;
    cyc(3'b011, 3'b001, "waw_g0");
    cyc(3'b010, 3'b010, "waw_g1");
    cyc(3'b000, 3'b000, "waw_idle");
    chk("waw_last", wd3, 64'hB);

    // Reset in the middle of a granted cycle
    req_addr[2] = 5'd12; req_data[2] = 64'hC;
    req_valid = 3'b111;
    #1;
    chk("mid_ready", W'(req_ready), W'(3'b100));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", W'(req_ready), W'(0));
    @(negedge clk);
    chk("mid_rst_we3", W'(we3), W'(0));
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_we3", W'(we3), W'(0));
    chk("post_rst_drop", W'(drop_cnt), W'(0));
    cyc(3'b111, 3'b001, "post_rst_g0");
    cyc(3'b000, 3'b000, "post_idle");

    // Saturation of the drop counter
    force dut.drop_cnt = 16'hFFFE;
    #1 release dut.drop_cnt;
    req_addr[0] = 5'd31;
    cyc(3'b001, 3'b001, "sat1");
    chk("sat_ffff", W'(drop_cnt), W'(16'hFFFF));
    cyc(3'b001, 3'b001, "sat2");
    cyc(3'b001, 3'b001, "sat3");
    chk("sat_nowrap", W'(drop_cnt), W'(16'hFFFF));
    cyc(3'b000, 3'b000, "end_idle");

    chk("q_empty", W'(exp_q.size()), W'(0));
    chk("wr_count", W'(nwr), W'(11));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
